// File: rtl/usb_arb_pkg.sv
// Shared constants for usb_bulk_in_arbiter: state encoding, default burst ceilings
// and header byte layout.
package usb_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HDR  = 2'd1;
  localparam state_t ST_XFER = 2'd2;

  localparam int unsigned MAX_BURST_HS = 512;
  localparam int unsigned MAX_BURST_FS = 64;

  localparam int unsigned HDR_CONT_BIT = 7;
  localparam int unsigned HDR_GNT_LSB  = 0;
  localparam int unsigned HDR_GNT_W    = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request found scanning from ptr
// upwards, modulo NUM_SRC.
module rr_pick #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned PW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [PW-1:0]      idx,
  output logic               any
);

  logic [PW:0] sum;

  // Walk offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    idx = '0;
    sum = '0;
    any = |req;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(NUM_SRC - 1 - i);
      if (sum >= (PW+1)'(NUM_SRC)) sum = sum - (PW+1)'(NUM_SRC);
      if (req[sum[PW-1:0]]) idx = sum[PW-1:0];
    end
  end

endmodule

// File: rtl/usb_bulk_in_arbiter.sv
// Round-robin, packet-atomic AXIS arbiter feeding the USB bulk IN stream with a per-grant
// byte ceiling. Define USB_ARB_HEADER_EN to prefix each burst with a header byte.
module usb_bulk_in_arbiter
  import usb_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned MAX_BURST = MAX_BURST_HS,
  parameter int unsigned CNTW      = $clog2(MAX_BURST)
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_SRC-1:0]     s_axis_tvalid_i,
  output logic [NUM_SRC-1:0]     s_axis_tready_o,
  input  logic [NUM_SRC-1:0]     s_axis_tlast_i,
  input  logic [8*NUM_SRC-1:0]   s_axis_tdata_i,
  output logic                   m_axis_tvalid_o,
  input  logic                   m_axis_tready_i,
  output logic                   m_axis_tlast_o,
  output logic [7:0]             m_axis_tdata_o,
  output logic [NUM_SRC-1:0]     grant_o,
  output logic                   busy_o
);

  localparam int unsigned GW = $clog2(NUM_SRC);
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_SRC - 1);
  localparam logic [CNTW-1:0] CEIL = CNTW'(MAX_BURST - 1);

  state_t          state_q, state_d;
  logic [GW-1:0]   gnt_q, gnt_d, rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [GW-1:0]   pick_idx;
  logic            pick_any;
  logic            sel_valid, sel_last, at_ceiling, hs;
  logic [7:0]      sel_data;

  rr_pick #(
    .NUM_SRC(NUM_SRC),
    .PW     (GW)
  ) u_pick (
    .req(s_axis_tvalid_i),
    .ptr(rr_ptr_q),
    .idx(pick_idx),
    .any(pick_any)
  );

  assign sel_valid  = s_axis_tvalid_i[gnt_q];
  assign sel_last   = s_axis_tlast_i[gnt_q];
  assign sel_data   = s_axis_tdata_i[{gnt_q, 3'b000} +: 8];
  assign at_ceiling = (count_q == CEIL);
  assign hs         = m_axis_tvalid_o & m_axis_tready_i;

`ifdef USB_ARB_HEADER_EN
  // One flag per source: its last burst was cut by the ceiling, not by its own tlast.
  logic [NUM_SRC-1:0] cont_q, cont_d;
  logic [7:0]         hdr_byte;

  always_comb begin
    hdr_byte = '0;
    hdr_byte[HDR_CONT_BIT] = cont_q[gnt_q];
    hdr_byte[HDR_GNT_LSB +: HDR_GNT_W] = HDR_GNT_W'(gnt_q);
  end
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
`ifdef USB_ARB_HEADER_EN
      cont_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
`ifdef USB_ARB_HEADER_EN
      cont_q   <= cont_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
`ifdef USB_ARB_HEADER_EN
    cont_d   = cont_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d = pick_idx;
`ifdef USB_ARB_HEADER_EN
          state_d = ST_HDR;
`else
          state_d = ST_XFER;
`endif
        end
      end
`ifdef USB_ARB_HEADER_EN
      ST_HDR: begin
        if (m_axis_tready_i) begin
          count_d = count_q + 1'b1;
          state_d = ST_XFER;
        end
      end
`endif
      ST_XFER: begin
        if (hs) begin
          if (m_axis_tlast_o) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            rr_ptr_d = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
`ifdef USB_ARB_HEADER_EN
            cont_d[gnt_q] = ~sel_last;
`endif
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_axis_tvalid_o = 1'b0;
    m_axis_tlast_o  = 1'b0;
    m_axis_tdata_o  = '0;
    s_axis_tready_o = '0;
    grant_o         = '0;
    busy_o          = (state_q != ST_IDLE);
    case (state_q)
`ifdef USB_ARB_HEADER_EN
      ST_HDR: begin
        m_axis_tvalid_o = 1'b1;
        m_axis_tdata_o  = hdr_byte;
        grant_o[gnt_q]  = 1'b1;
      end
`endif
      ST_XFER: begin
        m_axis_tvalid_o        = sel_valid;
        m_axis_tlast_o         = sel_last | at_ceiling;
        m_axis_tdata_o         = sel_data;
        s_axis_tready_o[gnt_q] = m_axis_tready_i;
        grant_o[gnt_q]         = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usb_bulk_in_arbiter.sv
// Directed bench for usb_bulk_in_arbiter: behavioural AXIS sources, a beat log of the
// output stream, and hand-built expected beat sequences.
module tb_usb_bulk_in_arbiter;

  localparam int unsigned NS = 4;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [NS-1:0]   s_tvalid = '0;
  logic [NS-1:0]   s_tready;
  logic [NS-1:0]   s_tlast = '0;
  logic [8*NS-1:0] s_tdata = '0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic            m_last;
  logic [7:0]      m_data;
  logic [NS-1:0]   grant;
  logic            busy;

  always #5 aclk = ~aclk;

  usb_bulk_in_arbiter #(
    .NUM_SRC  (NS),
    .MAX_BURST(512)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_axis_tvalid_i(s_tvalid),
    .s_axis_tready_o(s_tready),
    .s_axis_tlast_i (s_tlast),
    .s_axis_tdata_i (s_tdata),
    .m_axis_tvalid_o(m_valid),
    .m_axis_tready_i(m_ready),
    .m_axis_tlast_o (m_last),
    .m_axis_tdata_o (m_data),
    .grant_o        (grant),
    .busy_o         (busy)
  );

  int errors = 0;
  int checks = 0;

  int         src_len[NS];
  int         src_sent[NS];
  logic [7:0] src_base[NS];
  logic       fire[NS];

  logic [7:0]    log_data[$];
  logic          log_last[$];
  logic [NS-1:0] log_gnt[$];
  logic [7:0]    exp_data[$];
  logic          exp_last[$];
  logic [NS-1:0] exp_gnt[$];

  bit         rand_ready = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_srcs();
    for (int k = 0; k < NS; k++) begin
      s_tvalid[k]        = src_sent[k] < src_len[k];
      s_tdata[8*k +: 8]  = src_base[k] + 8'(src_sent[k]);
      s_tlast[k]         = (src_sent[k] == src_len[k] - 1);
    end
  endtask

  task automatic start_pkt(input int k, input int n, input logic [7:0] b);
    src_len[k]  = n;
    src_sent[k] = 0;
    src_base[k] = b;
    drive_srcs();
  endtask

  // Sample on the falling edge, update sources #1 after the rising edge.
  task automatic tick();
    @(negedge aclk);
    if (prev_stall) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(prev_data));
    end
    prev_stall = m_valid & ~m_ready;
    prev_data  = m_data;
    if (m_valid && m_ready) begin
      log_data.push_back(m_data);
      log_last.push_back(m_last);
      log_gnt.push_back(grant);
    end
    for (int k = 0; k < NS; k++) fire[k] = s_tvalid[k] & s_tready[k];
    @(posedge aclk);
    #1;
    for (int k = 0; k < NS; k++) if (fire[k]) src_sent[k]++;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    drive_srcs();
  endtask

  task automatic clear_logs();
    log_data.delete(); log_last.delete(); log_gnt.delete();
    exp_data.delete(); exp_last.delete(); exp_gnt.delete();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    rand_ready = 1'b0;
    m_ready = 1'b0;
    for (int k = 0; k < NS; k++) start_pkt(k, 0, 8'h00);
    tick();
    tick();
    aresetn = 1'b1;
    prev_stall = 1'b0;
    clear_logs();
  endtask

  task automatic push_beat(input logic [7:0] d, input logic l, input logic [NS-1:0] g);
    exp_data.push_back(d);
    exp_last.push_back(l);
    exp_gnt.push_back(g);
  endtask

  task automatic push_burst(input int k, input logic [7:0] first, input int n);
    for (int j = 0; j < n; j++) push_beat(first + 8'(j), j == n - 1, NS'(1) << k);
  endtask

  task automatic run_beats(input int n, input int budget, input string tag);
    int c = 0;
    while (log_data.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk({tag, "_beats_seen"}, 32'(log_data.size()), 32'(n));
  endtask

  task automatic compare_log(input string tag);
    int mism = 0;
    int first = -1;
    chk({tag, "_count"}, 32'(log_data.size()), 32'(exp_data.size()));
    for (int i = 0; i < log_data.size() && i < exp_data.size(); i++) begin
      if (log_data[i] !== exp_data[i] || log_last[i] !== exp_last[i] ||
          log_gnt[i] !== exp_gnt[i]) begin
        mism++;
        if (first < 0) first = i;
      end
    end
    chk($sformatf("%s_beat_mismatches(first_bad=%0d)", tag, first), 32'(mism), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tvalid"}, 32'(m_valid), 32'd0);
    chk({tag, "_tlast"}, 32'(m_last), 32'd0);
    chk({tag, "_tdata"}, 32'(m_data), 32'd0);
    chk({tag, "_tready"}, 32'(s_tready), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < NS; k++) begin
      src_len[k] = 0; src_sent[k] = 0; src_base[k] = '0; fire[k] = 1'b0;
    end
    drive_srcs();
    tick();
    chk_outputs_zero("rst_held");
    aresetn = 1'b1;
    tick();
    chk_outputs_zero("rst_released");

`ifndef USB_ARB_HEADER_EN
    // Single source, one-cycle arbitration latency, then a 10-byte pass-through.
    m_ready = 1'b1;
    start_pkt(1, 10, 8'h00);
    tick();
    chk("t1_no_beat_in_idle", 32'(log_data.size()), 32'd0);
    chk("t1_grant_after_arb", 32'(grant), 32'b0010);
    push_burst(1, 8'h00, 10);
    run_beats(10, 50, "t1");
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_grant_after", 32'(grant), 32'd0);
    compare_log("t1");

    // Simultaneous requests 0,2,3, then a second round that starts again at 0.
    do_reset();
    m_ready = 1'b1;
    start_pkt(0, 3, 8'h20);
    start_pkt(2, 3, 8'h40);
    start_pkt(3, 3, 8'h60);
    push_burst(0, 8'h20, 3);
    push_burst(2, 8'h40, 3);
    push_burst(3, 8'h60, 3);
    run_beats(9, 100, "t2a");
    start_pkt(3, 2, 8'h70);
    start_pkt(0, 2, 8'h30);
    push_burst(0, 8'h30, 2);
    push_burst(3, 8'h70, 2);
    run_beats(13, 60, "t2b");
    compare_log("t2");

    // 700-byte packet split at 512, pending source 1 served in between.
    do_reset();
    m_ready = 1'b1;
    start_pkt(0, 700, 8'h00);
    start_pkt(1, 4, 8'hA0);
    push_burst(0, 8'h00, 512);
    push_burst(1, 8'hA0, 4);
    push_burst(0, 8'h00, 188);
    run_beats(704, 1000, "t3");
    if (log_data.size() >= 704) begin
      chk("t3_split_last", 32'(log_last[511]), 32'd1);
      chk("t3_split_data", 32'(log_data[511]), 32'hFF);
      chk("t3_next_grant", 32'(log_gnt[512]), 32'b0010);
      chk("t3_tail_last_data", 32'(log_data[703]), 32'hBB);
    end
    compare_log("t3");

    // Random backpressure on a 64-byte burst.
    do_reset();
    rand_ready = 1'b1;
    start_pkt(3, 64, 8'h80);
    push_burst(3, 8'h80, 64);
    run_beats(64, 2000, "t4");
    rand_ready = 1'b0;
    m_ready = 1'b1;
    compare_log("t4");

    // Reset mid-burst at byte 5; rr_ptr must return to 0 (source 0 beats pending source 2).
    do_reset();
    m_ready = 1'b1;
    start_pkt(0, 2, 8'hD0);
    start_pkt(2, 20, 8'h10);
    push_burst(0, 8'hD0, 2);
    for (int j = 0; j < 5; j++) push_beat(8'h10 + 8'(j), 1'b0, 4'b0100);
    run_beats(7, 50, "t5a");
    aresetn = 1'b0;
    #1;
    chk_outputs_zero("t5_async_rst");
    tick();
    aresetn = 1'b1;
    start_pkt(0, 2, 8'hE0);
    push_burst(0, 8'hE0, 2);
    push_burst(2, 8'h15, 15);
    run_beats(24, 100, "t5b");
    compare_log("t5");
`else
    // Header mode: 700-byte packet from source 2 split into header+511 and header+189.
    do_reset();
    m_ready = 1'b1;
    start_pkt(2, 700, 8'h00);
    push_beat(8'h02, 1'b0, 4'b0100);
    push_burst(2, 8'h00, 511);
    push_beat(8'h82, 1'b0, 4'b0100);
    push_burst(2, 8'hFF, 189);
    run_beats(702, 1200, "th");
    if (log_data.size() >= 702) begin
      chk("th_hdr1", 32'(log_data[0]), 32'h02);
      chk("th_hdr2", 32'(log_data[512]), 32'h82);
      chk("th_split_last", 32'(log_last[511]), 32'd1);
    end
    compare_log("th");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
